// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per clock, sign applied at completion. result/exception are valid in the cycle result_rdy is high.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy,
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateT;

    localparam int CW = $clog2(WIDTH + 1);

    stateT            state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   opnd;
    logic             isNeg;
    logic             divZero;

    logic             startOp;
    logic [WIDTH:0]   extA, extB, absA, absB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH+1:0] divDiff;
    logic [2*WIDTH-1:0] prodMag, prodFix;
    logic [WIDTH:0]   prodTop;
    logic             mulOvf;
    logic [WIDTH-1:0] quoFix;

    assign startOp = ctrl_mult | ctrl_div;

    // One extra bit so the magnitude of the most negative operand is representable.
    assign extA = {operand_a[WIDTH-1], operand_a};
    assign extB = {operand_b[WIDTH-1], operand_b};
    assign absA = operand_a[WIDTH-1] ? -extA : extA;
    assign absB = operand_b[WIDTH-1] ? -extB : extB;

    // Multiply: {hi,lo} holds partial product and the not-yet-consumed multiplier bits.
    assign mulSum  = hi + (lo[0] ? opnd : '0);
    assign prodMag = {hi[WIDTH-1:0], lo};
    assign prodFix = isNeg ? -prodMag : prodMag;
    assign prodTop = prodFix[2*WIDTH-1:WIDTH-1];
    assign mulOvf  = !((&prodTop) || !(|prodTop));

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign divShift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    assign divDiff  = {1'b0, divShift} - {1'b0, opnd};
    assign quoFix   = isNeg ? -lo : lo;

    assign dbgState = state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            isNeg      <= 1'b0;
            divZero    <= 1'b0;
            result     <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            if (startOp) begin
                // A start in any state (including mid-operation) discards the current work.
                state   <= ctrl_mult ? MULT : DIV;
                cnt     <= CW'(WIDTH);
                busy    <= 1'b1;
                isNeg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                divZero <= !ctrl_mult && (operand_b == '0);
                hi      <= '0;
                lo      <= ctrl_mult ? absB[WIDTH-1:0] : absA[WIDTH-1:0];
                opnd    <= ctrl_mult ? absA : absB;
            end else begin
                case (state)
                    MULT, DIV: begin
                        if (state == DIV && divZero) begin
                            state      <= DONE;
                            result     <= '0;
                            exception  <= 1'b1;
                            result_rdy <= 1'b1;
                            busy       <= 1'b0;
                        end else if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                            if (cnt == CW'(1)) busy <= 1'b0;
                            if (state == MULT) begin
                                hi <= {1'b0, mulSum[WIDTH:1]};
                                lo <= {mulSum[0], lo[WIDTH-1:1]};
                            end else if (divDiff[WIDTH+1]) begin
                                hi <= divShift;
                                lo <= {lo[WIDTH-2:0], 1'b0};
                            end else begin
                                hi <= divDiff[WIDTH:0];
                                lo <= {lo[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            state      <= DONE;
                            result_rdy <= 1'b1;
                            if (state == MULT) begin
                                result    <= prodFix[WIDTH-1:0];
                                exception <= mulOvf;
                            end else begin
                                // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
                                result    <= quoFix;
                                exception <= !isNeg && lo[WIDTH-1];
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: directed corner cases, restart/abort, then random operations
// scored against a plain-arithmetic reference model.
module tb_multdiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         ctrl_mult = 1'b0;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] result;
    logic         exception;
    logic         result_rdy;
    logic         busy;
    logic [1:0]   dbgState;

    multdiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .operand_a(operand_a), .operand_b(operand_b),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .result(result),
        .exception(exception), .result_rdy(result_rdy), .busy(busy), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    logic [W:0]   exp_q[$];   // {exception, result}
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] holdRes = '0;
    logic         holdExc = 1'b0;

    // Reference: 64-bit arithmetic, truncating signed divide, explicit special cases.
    function automatic logic [W:0] model(input bit isMul, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       p;
        logic [W-1:0] r;
        int           q;
        if (isMul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[W-1:0];
            return {(p != longint'($signed(r))), r};
        end
        if (b == '0) return {1'b1, {W{1'b0}}};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every result_rdy pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [W:0] e;
        if (result_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy actual=%h expected=none", {exception, result});
            end else begin
                e = exp_q.pop_front();
                check("result", {exception, result}, e);
            end
        end
    end

    // Drives a one-cycle start; returns at the negedge after the sampling edge.
    task automatic issue(input bit mulC, input bit divC, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        ctrl_mult = mulC;
        ctrl_div  = divC;
        if (push) exp_q.push_back(model(mulC, a, b));
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int expLat, input int expBusy,
                             input logic [W:0] expVal);
        int lat = 0;
        int busyCnt = 0;
        bit holdBad = 1'b0;
        if (busy) busyCnt++;
        if ({exception, result} !== {holdExc, holdRes}) holdBad = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (result_rdy) begin
                lat = k;
                break;
            end
            if (busy) busyCnt++;
            if ({exception, result} !== {holdExc, holdRes}) holdBad = 1'b1;
        end
        check({name, "_latency"}, (W+1)'(lat), (W+1)'(expLat));
        check({name, "_busy"}, (W+1)'(busyCnt), (W+1)'(expBusy));
        check({name, "_hold"}, (W+1)'(holdBad), '0);
        @(negedge clk);
        check({name, "_rdy_width"}, (W+1)'(result_rdy), '0);
        holdRes = expVal[W-1:0];
        holdExc = expVal[W];
    endtask

    task automatic run_op(input string name, input bit mulC, input bit divC,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        bit dz;
        dz = !mulC && divC && (b == '0);
        issue(mulC, divC, a, b, 1'b1);
        wait_done(name, dz ? 1 : 33, dz ? 1 : 32, model(mulC, a, b));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = W'($urandom_range(0, 40)) - W'(20);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_result", {1'b0, result}, '0);
        check("reset_exception", (W+1)'(exception), '0);
        check("reset_rdy", (W+1)'(result_rdy), '0);
        check("reset_busy", (W+1)'(busy), '0);
        clr_n = 1'b1;

        run_op("mul_7_m6", 1, 0, 32'd7, 32'hFFFF_FFFA);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_m1_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000);
        run_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mul_min_1", 1, 0, 32'h8000_0000, 32'd1);
        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_by_0", 0, 1, 32'd7, 32'd0);
        run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_100_m7", 0, 1, 32'd100, 32'hFFFF_FFF9);
        run_op("both_ctrl", 1, 1, 32'd3, 32'd5);

        // Restart: divide started mid-multiply replaces it; only one result appears.
        issue(1, 0, 32'd12345, 32'd678, 1'b0);
        repeat (9) @(negedge clk);
        run_op("restart_div", 0, 1, 32'd20, 32'd3);

        // Abort by reset mid-operation.
        issue(1, 0, 32'd123, 32'd456, 1'b0);
        repeat (5) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("abort_result", {1'b0, result}, '0);
        check("abort_exception", (W+1)'(exception), '0);
        check("abort_rdy", (W+1)'(result_rdy), '0);
        check("abort_busy", (W+1)'(busy), '0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        holdRes = '0;
        holdExc = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            bit m;
            a = pick();
            b = pick();
            m = bit'($urandom_range(0, 1));
            run_op(m ? "rand_mul" : "rand_div", m, !m, a, b);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", (W+1)'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
